// File: rtl/ifmap_fifo_pkg.sv
// rtl/ifmap_fifo_pkg.sv - shared types and defaults for the ifmap staging FIFO
package ifmap_fifo_pkg;

    typedef enum logic {
        PUSH_SINGLE = 1'b0,
        PUSH_BURST  = 1'b1
    } push_mod_e;

    localparam int IFMAP_DATA_W = 8;
    localparam int IFMAP_BURST  = 4;

endpackage

// File: rtl/ifmap_burst_fifo.sv
// rtl/ifmap_burst_fifo.sv - ifmap staging FIFO with single/burst push and registered single pop
module ifmap_burst_fifo
    import ifmap_fifo_pkg::*;
#(
    parameter int DATA_W = IFMAP_DATA_W,
    parameter int DEPTH  = 8,
    parameter int BURST  = IFMAP_BURST,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    push_en,
    input  logic                    push_mod,
    input  logic [BURST*DATA_W-1:0] push_data,
    output logic                    push_drop,
    output logic                    full,
    input  logic                    pop_en,
    output logic [DATA_W-1:0]       pop_data,
    output logic                    pop_valid,
    output logic                    empty,
    output logic [CNT_W-1:0]        count
);

    localparam int PTR_W = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ifmap_burst_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if ((BURST < 1) || ((BURST & (BURST - 1)) != 0)) begin : g_bad_burst
        $error("ifmap_burst_fifo: BURST must be a power of 2");
    end
    if (BURST > DEPTH) begin : g_burst_too_big
        $error("ifmap_burst_fifo: BURST must not exceed DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  free;
    logic [CNT_W-1:0]  n_push;
    logic              is_burst;
    logic              push_acc;
    logic              pop_acc;
    logic              flush;

    assign flush    = rst | clear_i;
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign is_burst = (push_mod == PUSH_BURST);

    // Space is judged on the current count only; a same-cycle pop never makes room.
    assign free     = CNT_W'(DEPTH) - count;
    assign push_acc = push_en & (is_burst ? (free >= CNT_W'(BURST)) : (free != '0));
    assign pop_acc  = pop_en & ~empty;
    assign n_push   = !push_acc ? '0 : (is_burst ? CNT_W'(BURST) : CNT_W'(1));

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            push_drop <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(n_push);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count + n_push - CNT_W'(pop_acc);
            push_drop <= push_en & ~push_acc;
        end
    end

    // Burst lanes land at consecutive addresses and may wrap past DEPTH-1.
    always_ff @(posedge clk) begin
        if (!flush && push_acc) begin
            for (int i = 0; i < BURST; i++) begin
                if ((i == 0) || is_burst) begin
                    mem[wr_ptr + PTR_W'(i)] <= push_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_acc;
            if (pop_acc) begin
                pop_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_ifmap_burst_fifo.sv
// tb/tb_ifmap_burst_fifo.sv - self-checking bench for ifmap_burst_fifo
module tb_ifmap_burst_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_i;
    logic        push_en;
    logic        push_mod;
    logic [31:0] push_data;
    logic        push_drop;
    logic        full;
    logic        pop_en;
    logic [7:0]  pop_data;
    logic        pop_valid;
    logic        empty;
    logic [3:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: a plain queue of bytes plus the last registered outputs.
    logic [7:0] q[$];
    logic [7:0] m_pd;
    logic       m_pv;
    logic       m_drop;

    always #5 clk = ~clk;

    ifmap_burst_fifo #(.DATA_W(8), .DEPTH(8), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .push_en   (push_en),
        .push_mod  (push_mod),
        .push_data (push_data),
        .push_drop (push_drop),
        .full      (full),
        .pop_en    (pop_en),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .empty     (empty),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic pe, input logic pm,
                              input logic [31:0] pd, input logic po);
        int  free;
        bit  acc;
        if (r || c) begin
            q.delete();
            m_pd   = 8'h00;
            m_pv   = 1'b0;
            m_drop = 1'b0;
        end else begin
            free   = 8 - q.size();
            acc    = pe && (pm ? (free >= 4) : (free >= 1));
            m_pv   = po && (q.size() != 0);
            m_drop = pe && !acc;
            if (m_pv) m_pd = q.pop_front();
            if (acc) begin
                for (int i = 0; i < (pm ? 4 : 1); i++) q.push_back(pd[i*8 +: 8]);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic pe, input logic pm,
                       input logic [31:0] pd, input logic po);
        rst = r; clear_i = c; push_en = pe; push_mod = pm; push_data = pd; pop_en = po;
        model_step(r, c, pe, pm, pd, po);
        @(posedge clk);
        #1;
        chk("count",     32'(count),     32'(q.size()));
        chk("empty",     32'(empty),     32'(q.size() == 0));
        chk("full",      32'(full),      32'(q.size() == 8));
        chk("pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("pop_data",  32'(pop_data),  32'(m_pd));
        chk("push_drop", 32'(push_drop), 32'(m_drop));
    endtask

    typedef struct {
        logic        clr, pe, pm;
        logic [31:0] pd;
        logic        po;
        logic [3:0]  cnt;
        logic        pv;
        logic [7:0]  pdo;
        logic        drop;
    } vec_t;

    vec_t tv[24];
    int   nv;

    initial begin
        nv = 0;
        //             clr  pe   pm   data          po   cnt  pv   pdo    drop
        tv[nv++] = '{1'b0,1'b1,1'b1,32'h44332211,1'b0,4'd4,1'b0,8'h00,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd3,1'b1,8'h11,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd2,1'b1,8'h22,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd1,1'b1,8'h33,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd0,1'b1,8'h44,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd0,1'b0,8'h44,1'b0};
        tv[nv++] = '{1'b0,1'b1,1'b1,32'hD3D2D1D0,1'b0,4'd4,1'b0,8'h44,1'b0};
        tv[nv++] = '{1'b0,1'b1,1'b0,32'h000000E5,1'b0,4'd5,1'b0,8'h44,1'b0};
        tv[nv++] = '{1'b0,1'b1,1'b1,32'hBBBBBBBB,1'b0,4'd5,1'b0,8'h44,1'b1};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b0,4'd5,1'b0,8'h44,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd4,1'b1,8'hD0,1'b0};
        tv[nv++] = '{1'b0,1'b1,1'b1,32'h0C0B0A09,1'b0,4'd8,1'b0,8'hD0,1'b0};
        tv[nv++] = '{1'b0,1'b1,1'b0,32'h00000077,1'b1,4'd7,1'b1,8'hD1,1'b1};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd6,1'b1,8'hD2,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd5,1'b1,8'hD3,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd4,1'b1,8'hE5,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd3,1'b1,8'h09,1'b0};
        tv[nv++] = '{1'b0,1'b1,1'b1,32'h13121110,1'b1,4'd6,1'b1,8'h0A,1'b0};
        tv[nv++] = '{1'b1,1'b0,1'b0,32'h0,       1'b0,4'd0,1'b0,8'h00,1'b0};
        tv[nv++] = '{1'b0,1'b1,1'b0,32'h00000055,1'b1,4'd1,1'b0,8'h00,1'b0};
        tv[nv++] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,4'd0,1'b1,8'h55,1'b0};

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);

        for (int k = 0; k < nv; k++) begin
            cyc(1'b0, tv[k].clr, tv[k].pe, tv[k].pm, tv[k].pd, tv[k].po);
            chk($sformatf("vec%0d_count", k), 32'(count),     32'(tv[k].cnt));
            chk($sformatf("vec%0d_pv", k),    32'(pop_valid), 32'(tv[k].pv));
            chk($sformatf("vec%0d_pd", k),    32'(pop_data),  32'(tv[k].pdo));
            chk($sformatf("vec%0d_drop", k),  32'(push_drop), 32'(tv[k].drop));
            chk($sformatf("vec%0d_full", k),  32'(full),      32'(tv[k].cnt == 4'd8));
        end

        // Flush of a partly-filled FIFO via clear_i, then via rst.
        for (int pass = 0; pass < 2; pass++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'(8'h10 + i), 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("pre_flush_pd", 32'(pop_data), 32'h10);
            cyc(pass == 1, pass == 0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("flush_count", 32'(count),     32'd0);
            chk("flush_empty", 32'(empty),     32'd1);
            chk("flush_pv",    32'(pop_valid), 32'd0);
            chk("flush_pd",    32'(pop_data),  32'd0);
        end

        // Wrap: shift pointers to 3 so the second burst straddles index 7 -> 0.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h03020100, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h07060504, 1'b0);
        chk("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("wrap_pop", 32'(pop_data), 32'(i));
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Randomised traffic: push-heavy then pop-heavy phases to reach both ends.
        for (int k = 0; k < 600; k++) begin
            int pop_w;
            pop_w = ((k / 100) % 2 == 0) ? 1 : 3;
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 149) == 1,
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom, $urandom_range(0, 3) < pop_w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
